// File: rtl/ucsbece154b_perf_pkg.sv
// ----------------------------------------------------------------------------
// ucsbece154b_perf_pkg
// Shared definitions for the in-core performance monitor:
//   - counter indices (position of each counter in the event vector and in the
//     readout stream)
//   - readout FSM state encoding
// No ports; imported by ucsbece154b_perf_ctr and ucsbece154b_perf_counters.
// ----------------------------------------------------------------------------
package ucsbece154b_perf_pkg;

   localparam int CTR_CYCLES  = 0;
   localparam int CTR_INSTR   = 1;
   localparam int CTR_BR      = 2;
   localparam int CTR_BRMISS  = 3;
   localparam int CTR_JMP     = 4;
   localparam int CTR_JMPMISS = 5;
   localparam int NUM_CTRS    = 6;

   // Index of the final word of a readout stream.
   localparam logic [2:0] LAST_IDX = 3'd5;

   typedef enum logic {
      PERF_IDLE = 1'b0,
      PERF_SEND = 1'b1
   } perf_state_t;

endpackage

// File: rtl/ucsbece154b_perf_ctr.sv
// ----------------------------------------------------------------------------
// ucsbece154b_perf_ctr
// One WIDTH-bit event counter. Clear has priority over increment.
// Configuration macro: PERF_SATURATE_EN
//   defined   -> counter sticks at all-ones
//   undefined -> counter wraps modulo 2^WIDTH
// Ports:
//   clk    in   clock, rising edge
//   reset  in   asynchronous, active-high
//   clear  in   synchronous clear to zero
//   inc    in   add one at the next edge
//   count  out  current value
// ----------------------------------------------------------------------------
module ucsbece154b_perf_ctr
   import ucsbece154b_perf_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every flop samples the pre-edge value of every other flop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc) begin
`ifdef PERF_SATURATE_EN
         if (count != '1) begin
            count <= count + ONE;
         end
`else
         count <= count + ONE;
`endif
      end
   end

endmodule

// File: rtl/ucsbece154b_perf_counters.sv
// ----------------------------------------------------------------------------
// ucsbece154b_perf_counters
// In-core performance monitor. Execute-stage events are registered once, then
// drive six counters (cycles, instructions, branches, branch misses, jumps,
// jump misses). A snapshot request copies all live counters into shadow
// registers and streams them out, index 0..5, over a valid/ready port.
// Configuration macro: PERF_SATURATE_EN (saturating counters when defined,
// wrapping counters otherwise; handled inside ucsbece154b_perf_ctr).
// Ports:
//   clk, reset                 clock and asynchronous active-high reset
//   enable_i                   counting enable
//   stall_f_i                  Fetch stall; instruction count advances when low
//   branch_e_i, jump_e_i       branch / jal-jalr in Execute
//   pred_taken_e_i             prediction carried from Fetch
//   actual_taken_e_i           resolved PCSrcE
//   clear_i                    synchronous clear of live counters
//   snap_req_i                 request snapshot and readout
//   busy_o                     readout in progress
//   rd_valid_o, rd_ready_i     read handshake
//   rd_idx_o, rd_data_o        index and value of current word
//   rd_last_o                  final word (index 5)
// ----------------------------------------------------------------------------
module ucsbece154b_perf_counters
   import ucsbece154b_perf_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable_i,
   input  logic             stall_f_i,
   input  logic             branch_e_i,
   input  logic             jump_e_i,
   input  logic             pred_taken_e_i,
   input  logic             actual_taken_e_i,
   input  logic             clear_i,
   input  logic             snap_req_i,
   output logic             busy_o,
   output logic             rd_valid_o,
   input  logic             rd_ready_i,
   output logic [2:0]       rd_idx_o,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             rd_last_o
);

   logic [NUM_CTRS-1:0]            ev_d;
   logic [NUM_CTRS-1:0]            ev_q;
   logic [NUM_CTRS-1:0]            inc;
   logic [NUM_CTRS-1:0][WIDTH-1:0] live;
   logic [NUM_CTRS-1:0][WIDTH-1:0] shadow;
   perf_state_t                    state;
   logic [2:0]                     idx;

   // Raw event decode. A branch and a jump together are illegal upstream, but
   // both counts simply increment if it happens.
   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      ev_d              = '0;
      ev_d[CTR_CYCLES]  = 1'b1;
      ev_d[CTR_INSTR]   = !stall_f_i;
      ev_d[CTR_BR]      = branch_e_i;
      ev_d[CTR_BRMISS]  = branch_e_i && (pred_taken_e_i != actual_taken_e_i);
      ev_d[CTR_JMP]     = jump_e_i;
      ev_d[CTR_JMPMISS] = jump_e_i && (pred_taken_e_i != actual_taken_e_i);
   end

   // Event register: loads only while enabled and holds otherwise, so an event
   // captured just before enable drops is counted once counting resumes rather
   // than lost. Clear flushes it so nothing leaks in after the clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ev_q <= '0;
      end else if (clear_i) begin
         ev_q <= '0;
      end else if (enable_i) begin
         ev_q <= ev_d;
      end
   end

   // Counters only move while enabled.
   assign inc = enable_i ? ev_q : '0;

   for (genvar g = 0; g < NUM_CTRS; g++) begin : g_ctr
      ucsbece154b_perf_ctr #(
         .WIDTH (WIDTH)
      ) u_ctr (
         .clk   (clk),
         .reset (reset),
         .clear (clear_i),
         .inc   (inc[g]),
         .count (live[g])
      );
   end

   // Readout FSM. The shadow copy is taken from the pre-edge live values, so a
   // simultaneous clear never reaches the snapshot, and events still sitting in
   // the event register are excluded.
   // NOTE: the shadow bank is only six words, so it is reset along with the
   // rest of the state; this keeps rd_data_o defined from the first cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= PERF_IDLE;
         idx    <= 3'd0;
         shadow <= '0;
      end else begin
         case (state)
            PERF_IDLE: begin
               if (snap_req_i) begin
                  shadow <= live;
                  idx    <= 3'd0;
                  state  <= PERF_SEND;
               end
            end
            PERF_SEND: begin
               if (rd_ready_i) begin
                  if (idx == LAST_IDX) begin
                     idx   <= 3'd0;
                     state <= PERF_IDLE;
                  end else begin
                     idx <= idx + 3'd1;
                  end
               end
            end
            default: begin
               state <= PERF_IDLE;
               idx   <= 3'd0;
            end
         endcase
      end
   end

   // Outputs decode registered state only; rd_ready_i has no path to them.
   assign busy_o     = (state == PERF_SEND);
   assign rd_valid_o = busy_o;
   assign rd_idx_o   = idx;
   assign rd_last_o  = busy_o && (idx == LAST_IDX);

   always_comb begin
      rd_data_o = '0;
      if (busy_o) begin
         for (int i = 0; i < NUM_CTRS; i++) begin
            if (idx == i[2:0]) begin
               rd_data_o = shadow[i];
            end
         end
      end
   end

endmodule
